uc_secuenciada: RTL and testbench
=================================

# uc_secuenciada

Parametrised control unit for the single-cycle CPU with I/O: decodes the 6-bit opcode into datapath controls and adds a registered sequencer for three multi-cycle behaviours. These are a variable-length skip, I/O reads/writes that stall on a ready handshake with timeout, and a tracked call/return stack depth with error reporting. It drives the PC, register file, zero flag, stack and I/O port strobes.

## Interface
- `OPW`, 6: opcode width; decode uses the top 6 bits.
- `ALU_OPW`, 3: ALU operation field width, taken from `opcode[4:2]`.
- `SKIP_W`, 2: skip-count field width; count = `opcode[SKIP_W-1:0]`+1.
- `STACK_DEPTH`, 16: return-stack entries tracked.
- `IO_TIMEOUT`, 15: maximum wait cycles for `io_ready`; must be ≥1.
- Clocking: one clock `clk`; reset `reset` is synchronous and active-high.
- `clk` in 1: clock, all state on rising edge.
- `reset` in 1: synchronous, active-high.
- `opcode` in OPW: current instruction opcode.
- `s_z` in 1: zero flag.
- `io_ready` in 1: I/O device completes the current access.
- `s_inc` out 1: PC mux, 1 = PC+1, 0 = jump target.
- `s_inm` out 1: register write mux, 1 = immediate.
- `s_in` out 1: register write mux, 1 = I/O input data.
- `we3` out 1: register file write.
- `wez` out 1: zero flag write.
- `wesp`, `push`, `pop` out 1 each: stack controls.
- `op_alu` out ALU_OPW: ALU operation.
- `pc_en` out 1: PC register load enable.
- `io_rd`, `io_wr` out 1 each: I/O strobes, held for the whole access.
- `skipping` out 1: high in SKIP state.
- `stack_err` out 1: sticky; set on overflow or underflow.
- `io_err` out 1: sticky; set on I/O timeout.

## Operation
- States: EXEC, SKIP, IO_WAIT. Outputs are combinational from state, opcode, `s_z`, `io_ready` and the counters; state and counters are registered.
- Defaults, every cycle: `s_inc`=1, `pc_en`=1; all other strobes 0; `op_alu` = `opcode[4:2]` at all times.
- EXEC decode:
  - `0xxxxx` ALU: `we3`=`wez`=1.
  - `1000xx` LOADI: `s_inm`=`we3`=1.
  - `1001xx` IN: `io_rd`=1. If `io_ready` is high, `s_in`=`we3`=1 this cycle. Otherwise `pc_en`=0, `we3`=0, next state IO_WAIT.
  - `1010xx` OUT: `io_wr`=1. If `io_ready` is low, `pc_en`=0, next state IO_WAIT.
  - `110000` J: `s_inc`=0.
  - `110001` JZ: `s_inc`=!`s_z`.
  - `110010` JNZ: `s_inc`=`s_z`.
  - `110100` CALL: `wesp`=`push`=1, `depth`+1. If `depth`==STACK_DEPTH: no push, `stack_err` set, PC+1.
  - `110101` RET: `wesp`=`pop`=1, `s_inc`=0, `depth`−1. If `depth`==0: no pop, `stack_err` set, `s_inc`=1.
  - `1110nn` SKIP: `scnt` loaded with nn+1, next state SKIP.
  - Any other opcode: NOP.
- SKIP: PC advances, all writes and strobes 0, `scnt`−1 each cycle. Returns to EXEC in the cycle `scnt`==1. Exactly nn+1 instructions are discarded.
- IO_WAIT:
  - `pc_en`=0; `io_rd`/`io_wr` held per opcode; `wcnt`+1 each cycle.
  - When `io_ready`=1: pc_en=1; IN also drives `s_in`=`we3`=1. Next state EXEC.
  - When `wcnt`==IO_TIMEOUT without ready: `io_err` set, pc_en=1, no register write, next state EXEC.
- `wcnt` clears on every entry to IO_WAIT.

## Timing
- Decode is 0-cycle: controls are valid in the same cycle as `opcode`.
- SKIP n costs 1+n cycles. I/O with ready at wait-cycle k costs 1+k cycles. Timeout costs 1+IO_TIMEOUT cycles.
- Reset, including mid-SKIP or mid-IO_WAIT:
  - Next state EXEC; `depth`, `scnt`, `wcnt`, `stack_err`, `io_err` all cleared.
  - While `reset`=1, all outputs are 0 except `s_inc`=1, `op_alu` (follows opcode), and `pc_en`=0.
- `io_ready` asserted in the same cycle the timeout is reached: ready wins, no error.
- Sticky errors clear only on reset.

## Structure
- Package `uc_pkg`: opcode constants (OP_J, OP_JZ, OP_JNZ, OP_CALL, OP_RET, OP_SKIP, OP_LOADI, OP_IN, OP_OUT) and the state enum.
- One sub-module `uc_stack_cnt`: saturating depth counter, parameter STACK_DEPTH. Outputs `full`, `empty`; input `reset`.

## Test plan
- `000100`, then `110001` with `s_z`=1 → `we3`=`wez`=1, `op_alu`=3'b001; then `s_inc`=0.
- `111010` (skip 3) → `skipping` high for exactly 3 cycles, `we3`=0 throughout, back in EXEC on the 5th cycle.
- `100100` IN with `io_ready` low 4 cycles, then high → `pc_en`=0 for 4 cycles; in cycle 5 `s_in`=`we3`=`pc_en`=1.
- `101000` OUT, `io_ready` never rises, IO_TIMEOUT=15 → `io_err`=1 after 16 cycles, `pc_en`=1 in that cycle.
- 17 CALLs with STACK_DEPTH=16 → 17th has `push`=0 and sets `stack_err`. RET at depth 0 → `pop`=0, `s_inc`=1.
- `reset` raised mid-skip (`scnt`=2) → next cycle EXEC, `skipping`=0, `stack_err`=`io_err`=0.

Source files
------------

// File: rtl/uc_pkg.sv
// Shared opcode constants and sequencer state encoding for the control unit.
package uc_pkg;

    typedef enum logic [1:0] {
        ST_EXEC    = 2'd0,
        ST_SKIP    = 2'd1,
        ST_IO_WAIT = 2'd2
    } state_e;

    // Full-opcode encodings (top 6 bits)
    localparam logic [5:0] OP_J    = 6'b110000;
    localparam logic [5:0] OP_JZ   = 6'b110001;
    localparam logic [5:0] OP_JNZ  = 6'b110010;
    localparam logic [5:0] OP_CALL = 6'b110100;
    localparam logic [5:0] OP_RET  = 6'b110101;

    // Four-bit prefixes; the low two bits are operands or don't-care
    localparam logic [3:0] OP_LOADI = 4'b1000;
    localparam logic [3:0] OP_IN    = 4'b1001;
    localparam logic [3:0] OP_OUT   = 4'b1010;
    localparam logic [3:0] OP_SKIP  = 4'b1110;

endpackage

// File: rtl/uc_stack_cnt.sv
// Saturating return-stack depth tracker; reports full and empty to the sequencer.
module uc_stack_cnt #(
    parameter int unsigned STACK_DEPTH = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic dec,
    output logic full,
    output logic empty
);

    localparam int unsigned DW = $clog2(STACK_DEPTH + 1);

    logic [DW-1:0] depth_q;
    logic [DW-1:0] depth_d;

    assign full  = (depth_q == DW'(STACK_DEPTH));
    assign empty = (depth_q == '0);

    always_comb begin
        depth_d = depth_q;
        if (inc && !dec && !full) begin
            depth_d = depth_q + DW'(1);
        end else if (dec && !inc && !empty) begin
            depth_d = depth_q - DW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            depth_q <= '0;
        end else begin
            depth_q <= depth_d;
        end
    end

endmodule

// File: rtl/uc_secuenciada.sv
// Control unit: 0-cycle opcode decode plus a registered sequencer for skip,
// stalled I/O with timeout, and call/return depth checking.
module uc_secuenciada
    import uc_pkg::*;
#(
    parameter int unsigned OPW         = 6,
    parameter int unsigned ALU_OPW     = 3,
    parameter int unsigned SKIP_W      = 2,
    parameter int unsigned STACK_DEPTH = 16,
    parameter int unsigned IO_TIMEOUT  = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [OPW-1:0]     opcode,
    input  logic               s_z,
    input  logic               io_ready,
    output logic               s_inc,
    output logic               s_inm,
    output logic               s_in,
    output logic               we3,
    output logic               wez,
    output logic               wesp,
    output logic               push,
    output logic               pop,
    output logic [ALU_OPW-1:0] op_alu,
    output logic               pc_en,
    output logic               io_rd,
    output logic               io_wr,
    output logic               skipping,
    output logic               stack_err,
    output logic               io_err
);

    localparam int unsigned SCNT_W = SKIP_W + 1;
    localparam int unsigned WCNT_W = $clog2(IO_TIMEOUT + 1);

    state_e             state_q, state_d;
    logic [SCNT_W-1:0]  scnt_q, scnt_d;
    logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
    logic               stack_err_q, stack_err_d;
    logic               io_err_q, io_err_d;

    logic [5:0]         top6;
    logic               stk_push, stk_pop;
    logic               stk_full, stk_empty;
    logic               wait_last;
    logic               io_is_in;

    assign top6      = opcode[OPW-1 -: 6];
    assign io_is_in  = (top6[5:2] == OP_IN);
    // The current wait cycle is the last one the device is allowed
    assign wait_last = (wcnt_q == WCNT_W'(IO_TIMEOUT - 1));

    // Sticky flags read as zero while reset is held
    assign stack_err = stack_err_q & ~reset;
    assign io_err    = io_err_q & ~reset;

    uc_stack_cnt #(
        .STACK_DEPTH(STACK_DEPTH)
    ) u_stack_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (stk_push),
        .dec  (stk_pop),
        .full (stk_full),
        .empty(stk_empty)
    );

    always_comb begin
        state_d     = state_q;
        scnt_d      = scnt_q;
        wcnt_d      = wcnt_q;
        stack_err_d = stack_err_q;
        io_err_d    = io_err_q;
        s_inc       = 1'b1;
        pc_en       = 1'b1;
        s_inm       = 1'b0;
        s_in        = 1'b0;
        we3         = 1'b0;
        wez         = 1'b0;
        wesp        = 1'b0;
        push        = 1'b0;
        pop         = 1'b0;
        io_rd       = 1'b0;
        io_wr       = 1'b0;
        skipping    = 1'b0;
        stk_push    = 1'b0;
        stk_pop     = 1'b0;
        op_alu      = ALU_OPW'(top6[4:2]);

        if (reset) begin
            pc_en = 1'b0;
        end else begin
            case (state_q)
                ST_EXEC: begin
                    if (!top6[5]) begin
                        we3 = 1'b1;
                        wez = 1'b1;
                    end else begin
                        case (top6[5:2])
                            OP_LOADI: begin
                                s_inm = 1'b1;
                                we3   = 1'b1;
                            end
                            OP_IN: begin
                                io_rd = 1'b1;
                                if (io_ready) begin
                                    s_in = 1'b1;
                                    we3  = 1'b1;
                                end else begin
                                    pc_en   = 1'b0;
                                    wcnt_d  = '0;
                                    state_d = ST_IO_WAIT;
                                end
                            end
                            OP_OUT: begin
                                io_wr = 1'b1;
                                if (!io_ready) begin
                                    pc_en   = 1'b0;
                                    wcnt_d  = '0;
                                    state_d = ST_IO_WAIT;
                                end
                            end
                            OP_SKIP: begin
                                scnt_d  = SCNT_W'(opcode[SKIP_W-1:0]) + SCNT_W'(1);
                                state_d = ST_SKIP;
                            end
                            default: begin
                                case (top6)
                                    OP_J:   s_inc = 1'b0;
                                    OP_JZ:  s_inc = ~s_z;
                                    OP_JNZ: s_inc = s_z;
                                    OP_CALL: begin
                                        if (stk_full) begin
                                            stack_err_d = 1'b1;
                                        end else begin
                                            wesp     = 1'b1;
                                            push     = 1'b1;
                                            s_inc    = 1'b0;
                                            stk_push = 1'b1;
                                        end
                                    end
                                    OP_RET: begin
                                        if (stk_empty) begin
                                            stack_err_d = 1'b1;
                                        end else begin
                                            wesp    = 1'b1;
                                            pop     = 1'b1;
                                            s_inc   = 1'b0;
                                            stk_pop = 1'b1;
                                        end
                                    end
                                    default: ;
                                endcase
                            end
                        endcase
                    end
                end
                ST_SKIP: begin
                    skipping = 1'b1;
                    scnt_d   = scnt_q - SCNT_W'(1);
                    if (scnt_q == SCNT_W'(1)) begin
                        state_d = ST_EXEC;
                    end
                end
                ST_IO_WAIT: begin
                    pc_en  = 1'b0;
                    io_rd  = io_is_in;
                    io_wr  = ~io_is_in;
                    wcnt_d = wcnt_q + WCNT_W'(1);
                    if (io_ready) begin
                        pc_en   = 1'b1;
                        s_in    = io_is_in;
                        we3     = io_is_in;
                        state_d = ST_EXEC;
                    end else if (wait_last) begin
                        io_err_d = 1'b1;
                        pc_en    = 1'b1;
                        state_d  = ST_EXEC;
                    end
                end
                default: state_d = ST_EXEC;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_EXEC;
            scnt_q      <= '0;
            wcnt_q      <= '0;
            stack_err_q <= 1'b0;
            io_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            scnt_q      <= scnt_d;
            wcnt_q      <= wcnt_d;
            stack_err_q <= stack_err_d;
            io_err_q    <= io_err_d;
        end
    end

endmodule

// File: tb/tb_uc_secuenciada.sv
// Bench for uc_secuenciada: directed scenarios plus randomized traffic against a
// cycle-level behavioural model of the instruction set.
module tb_uc_secuenciada;

    localparam int STACK_DEPTH = 16;
    localparam int IO_TIMEOUT  = 15;

    logic       clk = 1'b0;
    logic       reset, s_z, io_ready;
    logic [5:0] opcode;
    logic       s_inc, s_inm, s_in, we3, wez, wesp, push, pop;
    logic [2:0] op_alu;
    logic       pc_en, io_rd, io_wr, skipping, stack_err, io_err;

    int total = 0;
    int bad   = 0;

    // Model state: instructions still to discard, pending I/O, waits done, call depth
    int m_skip  = 0;
    int m_wait  = 0;
    int m_wt    = 0;
    int m_depth = 0;
    int m_serr  = 0;
    int m_ierr  = 0;

    always #5 clk = ~clk;

    uc_secuenciada #(
        .OPW(6), .ALU_OPW(3), .SKIP_W(2),
        .STACK_DEPTH(STACK_DEPTH), .IO_TIMEOUT(IO_TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .s_z(s_z), .io_ready(io_ready),
        .s_inc(s_inc), .s_inm(s_inm), .s_in(s_in), .we3(we3), .wez(wez),
        .wesp(wesp), .push(push), .pop(pop), .op_alu(op_alu), .pc_en(pc_en),
        .io_rd(io_rd), .io_wr(io_wr), .skipping(skipping),
        .stack_err(stack_err), .io_err(io_err)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, got, exp);
        end
    endtask

    // Expected outputs for one cycle, then advance the model past the clock edge
    task automatic model(input logic r, input logic [5:0] op, input logic sz,
                         input logic rdy, output logic [16:0] e);
        logic inc, inm, sin, w3, wz, wsp, psh, pp, pc, rd, wr, skp, serr, ierr;
        inc = 1; pc = 1; inm = 0; sin = 0; w3 = 0; wz = 0; wsp = 0; psh = 0; pp = 0;
        rd = 0; wr = 0; skp = 0;
        serr = (m_serr != 0) && !r;
        ierr = (m_ierr != 0) && !r;
        if (r) begin
            pc = 0;
            m_skip = 0; m_wait = 0; m_wt = 0; m_depth = 0; m_serr = 0; m_ierr = 0;
        end else if (m_skip > 0) begin
            skp = 1;
            m_skip--;
        end else if (m_wait != 0) begin
            rd = (op[5:2] == 4'b1001);
            wr = !rd;
            if (rdy) begin
                sin = rd; w3 = rd; m_wait = 0;
            end else if (m_wt + 1 == IO_TIMEOUT) begin
                m_ierr = 1; m_wait = 0;
            end else begin
                pc = 0;
            end
            m_wt++;
        end else if (op[5] == 1'b0) begin
            w3 = 1; wz = 1;
        end else begin
            case (op[5:2])
                4'b1000: begin inm = 1; w3 = 1; end
                4'b1001: begin
                    rd = 1;
                    if (rdy) begin sin = 1; w3 = 1; end
                    else begin pc = 0; m_wait = 1; m_wt = 0; end
                end
                4'b1010: begin
                    wr = 1;
                    if (!rdy) begin pc = 0; m_wait = 1; m_wt = 0; end
                end
                4'b1110: m_skip = int'(op[1:0]) + 1;
                4'b1100: begin
                    if (op[1:0] == 2'd0) inc = 0;
                    else if (op[1:0] == 2'd1) inc = !sz;
                    else if (op[1:0] == 2'd2) inc = sz;
                end
                4'b1101: begin
                    if (op[1:0] == 2'd0) begin
                        if (m_depth == STACK_DEPTH) m_serr = 1;
                        else begin wsp = 1; psh = 1; inc = 0; m_depth++; end
                    end else if (op[1:0] == 2'd1) begin
                        if (m_depth == 0) m_serr = 1;
                        else begin wsp = 1; pp = 1; inc = 0; m_depth--; end
                    end
                end
                default: ;
            endcase
        end
        e = {inc, inm, sin, w3, wz, wsp, psh, pp, op[4:2], pc, rd, wr, skp, serr, ierr};
    endtask

    // Drive one cycle at the falling edge and compare every output to the model
    task automatic step(input logic r, input logic [5:0] op, input logic sz, input logic rdy);
        logic [16:0] e, g;
        @(negedge clk);
        reset = r; opcode = op; s_z = sz; io_ready = rdy;
        #1;
        model(r, op, sz, rdy, e);
        g = {s_inc, s_inm, s_in, we3, wez, wesp, push, pop, op_alu,
             pc_en, io_rd, io_wr, skipping, stack_err, io_err};
        chk("outputs", 32'(g), 32'(e));
    endtask

    function automatic logic [5:0] rand_op();
        logic [31:0] r;
        r = $urandom;
        case (r[2:0])
            3'd0: rand_op = {1'b0, r[12:8]};
            3'd1: rand_op = {4'b1000, r[9:8]};
            3'd2: rand_op = {4'b1001, r[9:8]};
            3'd3: rand_op = {4'b1010, r[9:8]};
            3'd4: rand_op = {4'b1100, r[9:8]};
            3'd5: rand_op = {4'b1101, r[9:8]};
            3'd6: rand_op = {4'b1110, r[9:8]};
            default: rand_op = r[13:8];
        endcase
    endfunction

    initial begin
        int cnt;
        logic [5:0] op;
        reset = 1'b1; opcode = '0; s_z = 1'b0; io_ready = 1'b0;

        // Reset state
        step(1, 6'b000100, 0, 0);
        step(1, 6'b000100, 0, 0);
        chk("rst_pc_en", 32'(pc_en), 32'd0);
        chk("rst_s_inc", 32'(s_inc), 32'd1);
        chk("rst_op_alu", 32'(op_alu), 32'd1);

        // ALU then JZ taken
        step(0, 6'b000100, 0, 0);
        chk("alu_we3_wez", 32'({we3, wez}), 32'd3);
        chk("alu_op", 32'(op_alu), 32'b001);
        step(0, 6'b110001, 1, 0);
        chk("jz_s_inc", 32'(s_inc), 32'd0);

        // Skip 3: three discarded cycles then EXEC on the fifth
        step(0, 6'b111010, 0, 0);
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            step(0, 6'b000001, 0, 0);
            if (skipping && !we3) cnt++;
        end
        chk("skip_cycles", 32'(cnt), 32'd3);
        step(0, 6'b000001, 0, 0);
        chk("skip_done_we3", 32'({skipping, we3}), 32'b01);

        // IN with ready arriving at wait cycle 4
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            step(0, 6'b100100, 0, 0);
            if (!pc_en && io_rd) cnt++;
        end
        chk("in_stall", 32'(cnt), 32'd4);
        step(0, 6'b100100, 0, 1);
        chk("in_done", 32'({s_in, we3, pc_en}), 32'b111);

        // OUT with ready on the very last allowed wait cycle: no error
        for (int i = 0; i < IO_TIMEOUT; i++) step(0, 6'b101000, 0, 0);
        step(0, 6'b101000, 0, 1);
        step(0, 6'b000000, 0, 0);
        chk("ready_at_limit", 32'(io_err), 32'd0);

        // OUT timeout
        cnt = 0;
        for (int i = 0; i < IO_TIMEOUT + 1; i++) begin
            step(0, 6'b101000, 0, 0);
            if (!pc_en) cnt++;
        end
        chk("to_stall", 32'(cnt), 32'(IO_TIMEOUT));
        chk("to_pc_en", 32'(pc_en), 32'd1);
        step(0, 6'b000000, 0, 0);
        chk("to_io_err", 32'(io_err), 32'd1);

        // Stack overflow on the 17th call
        step(1, 6'b000000, 0, 0);
        for (int i = 0; i < STACK_DEPTH + 1; i++) step(0, 6'b110100, 0, 0);
        chk("ovf_push", 32'({push, wesp, s_inc}), 32'b001);
        step(0, 6'b000000, 0, 0);
        chk("ovf_err", 32'(stack_err), 32'd1);

        // Underflow on RET at depth 0
        step(1, 6'b000000, 0, 0);
        step(0, 6'b110101, 0, 0);
        chk("udf_ret", 32'({pop, s_inc}), 32'b01);

        // Reset in the middle of a skip clears everything
        step(0, 6'b111010, 0, 0);
        step(0, 6'b000000, 0, 0);
        step(1, 6'b000000, 0, 0);
        step(0, 6'b000000, 0, 0);
        chk("rst_skip", 32'({skipping, stack_err, io_err, we3}), 32'b0001);

        // Randomized traffic; opcode is held while the model has an access pending
        op = 6'b000000;
        for (int i = 0; i < 4000; i++) begin
            if (m_wait == 0 || m_skip > 0) op = rand_op();
            step(($urandom_range(0, 299) == 0), op, 1'($urandom),
                 ($urandom_range(0, 5) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
